// File: rtl/image_pkg.sv
// Shared constants and types for the image loader.
//   SYNC_BYTE : byte that marks the start of an image in the stream
//   WORD_W    : width of one RAM word, {r_sin[6:1], l_sin[6:1]}
//   PLANES    : bit planes per image; an image is SIDX_MAX*PLANES words
package image_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned WORD_W    = 12;
  localparam int unsigned PLANES    = 8;

  typedef enum logic [1:0] {
    Hunt,
    Load,
    WaitSwap
  } state_e;

endpackage

// File: rtl/image_loader_if.sv
// Byte-stream input, frame handshake and front-bank read port of the image loader.
//   slave  : the loader side (takes bytes, drives in_ready and read data)
//   master : the stream source / panel driver side
interface image_loader_if #(
  parameter int unsigned ADDR_W = 13
);
  import image_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              frame_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              front_bank;
  logic              load_busy;

  modport slave (
    input  in_data, in_valid, frame_done, rd_addr,
    output in_ready, rd_data, front_bank, load_busy
  );

  modport master (
    output in_data, in_valid, frame_done, rd_addr,
    input  in_ready, rd_data, front_bank, load_busy
  );

endinterface

// File: rtl/image_ram.sv
// Double-buffered image RAM: 2 banks of 2**ADDR_W words, one write port and one
// registered read port. The bank is the MSB of both addresses.
//   clock, reset_n : clock and async active-low reset (resets only the read register)
//   we/waddr/wdata : write port, written on the rising edge
//   raddr/rdata    : read port, one cycle latency
module image_ram
  import image_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W:0]   raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned Depth = 2 * (2 ** ADDR_W);

  logic [WORD_W-1:0] mem [Depth];
  logic [WORD_W-1:0] rdata_d, rdata_q;

  // Contents survive reset on purpose: the front bank keeps showing its image.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb rdata_d = mem[raddr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/image_loader.sv
// Image loader: hunts for SYNC_BYTE, unpacks three stream bytes into two 12-bit
// words, fills the back bank and swaps banks on the driver's frame boundary.
//   clock, reset_n : clock and async active-low reset
//   bus (slave)    : byte stream in/ready, frame_done, front-bank read port,
//                    front_bank and load_busy status
// Parameters: SIDX_MAX shift clocks per plane; ADDR_W with 2**ADDR_W >= SIDX_MAX*8.
module image_loader
  import image_pkg::*;
#(
  parameter int unsigned SIDX_MAX = 576,
  parameter int unsigned ADDR_W   = 13
) (
  input  logic         clock,
  input  logic         reset_n,
  image_loader_if.slave bus
);

  localparam int unsigned       ImgWords = SIDX_MAX * PLANES;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(ImgWords - 1);

  state_e            state_d, state_q;
  logic [1:0]        phase_d, phase_q;
  logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
  logic [7:0]        b0_d, b0_q;
  logic [3:0]        b1_lo_d, b1_lo_q;
  logic              front_bank_d, front_bank_q;

  logic              xfer;
  logic              we;
  logic [WORD_W-1:0] wdata;

  // Gated by reset_n so the source sees in_ready low for the whole reset.
  assign bus.in_ready  = reset_n & (state_q != WaitSwap);
  assign bus.load_busy = (state_q != Hunt);
  assign bus.front_bank = front_bank_q;
  assign xfer = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    wr_addr_d    = wr_addr_q;
    b0_d         = b0_q;
    b1_lo_d      = b1_lo_q;
    front_bank_d = front_bank_q;
    we           = 1'b0;
    wdata        = '0;

    unique case (state_q)
      Hunt: begin
        if (xfer && (bus.in_data == SYNC_BYTE)) begin
          state_d   = Load;
          wr_addr_d = '0;
          phase_d   = 2'd0;
        end
      end
      Load: begin
        // Sync byte is plain data here.
        if (xfer) begin
          case (phase_q)
            2'd0: begin
              b0_d    = bus.in_data;
              phase_d = 2'd1;
            end
            2'd1: begin
              we      = 1'b1;
              wdata   = {b0_q, bus.in_data[7:4]};
              b1_lo_d = bus.in_data[3:0];
              phase_d = 2'd2;
            end
            default: begin
              we      = 1'b1;
              wdata   = {b1_lo_q, bus.in_data};
              phase_d = 2'd0;
            end
          endcase
        end
        if (we) begin
          if (wr_addr_q == LastAddr) begin
            state_d   = WaitSwap;
            phase_d   = 2'd0;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      WaitSwap: begin
        if (bus.frame_done) begin
          front_bank_d = ~front_bank_q;
          state_d      = Hunt;
          wr_addr_d    = '0;
        end
      end
      default: state_d = Hunt;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= Hunt;
      phase_q      <= 2'd0;
      wr_addr_q    <= '0;
      b0_q         <= '0;
      b1_lo_q      <= '0;
      front_bank_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      wr_addr_q    <= wr_addr_d;
      b0_q         <= b0_d;
      b1_lo_q      <= b1_lo_d;
      front_bank_q <= front_bank_d;
    end
  end

  // Read with the next-state bank so a read sampled on the swap edge already
  // sees the newly displayed image.
  image_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we),
    .waddr   ({~front_bank_q, wr_addr_q}),
    .wdata   (wdata),
    .raddr   ({front_bank_d, bus.rd_addr}),
    .rdata   (bus.rd_data)
  );

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with SIDX_MAX=4 (32 words, 48 data bytes).
module tb_image_loader;
  import image_pkg::*;

  localparam int unsigned AW    = 5;
  localparam int unsigned NWORD = 32;
  localparam int unsigned NBYTE = 48;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  image_loader_if #(.ADDR_W(AW)) bus ();

  image_loader #(
    .SIDX_MAX (4),
    .ADDR_W   (AW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pat_a [NBYTE];
  logic [7:0]  pat_b [NBYTE];
  logic [11:0] exp_a [NWORD];
  logic [11:0] exp_b [NWORD];

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       fd;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_fb;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    int w;
    n = 0;
    if (gaps) begin
      while (($urandom_range(1) == 1) && (n < 4)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = SYNC_BYTE;
        tick();
        n++;
      end
    end
    w = 0;
    while (!bus.in_ready && (w < 100)) begin
      tick();
      w++;
    end
    if (w == 100) begin
      errors++;
      $display("FAIL ready_timeout: got in_ready 0 expected 1 within 100 cycles");
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [11:0] d);
    bus.rd_addr = a;
    tick();
    d = bus.rd_data;
  endtask

  task automatic pulse_fd();
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
  endtask

  task automatic check_image(input string name, input logic [11:0] exp [NWORD]);
    logic [11:0] d;
    int bad;
    bad = 0;
    for (int i = 0; i < NWORD; i++) begin
      read_word(AW'(i), d);
      checks++;
      if (d !== exp[i]) begin
        errors++;
        bad++;
        if (bad < 4) $display("FAIL %s[%0d]: got %0h expected %0h", name, i, d, exp[i]);
      end
    end
  endtask

  function automatic void pack(input logic [7:0] b [NBYTE], output logic [11:0] w [NWORD]);
    for (int k = 0; k < NWORD / 2; k++) begin
      w[2*k]   = {b[3*k], b[3*k+1][7:4]};
      w[2*k+1] = {b[3*k+1][3:0], b[3*k+2]};
    end
  endfunction

  initial begin
    logic [11:0] d;

    for (int i = 0; i < NBYTE; i++) begin
      case (i % 3)
        0:       pat_a[i] = 8'h12;
        1:       pat_a[i] = 8'h34;
        default: pat_a[i] = 8'h56;
      endcase
      pat_b[i] = 8'(i * 37 + 5);
    end
    pack(pat_a, exp_a);
    pack(pat_b, exp_b);

    //            data   v     fd    ready busy  fb
    vecs[0] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.frame_done = 1'b0;
    bus.rd_addr    = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_load_busy", 32'(bus.load_busy), 0);
    chk("rst_front_bank", 32'(bus.front_bank), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    reset_n = 1'b1;
    #1;
    chk("ready_after_release", 32'(bus.in_ready), 1);

    // Hunt / sync / first data byte, with frame_done in HUNT and LOAD
    for (int i = 0; i < 4; i++) begin
      bus.in_data    = vecs[i].data;
      bus.in_valid   = vecs[i].valid;
      bus.frame_done = vecs[i].fd;
      tick();
      chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_busy", i), 32'(bus.load_busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_fb", i), 32'(bus.front_bank), 32'(vecs[i].exp_fb));
    end
    bus.in_valid   = 1'b0;
    bus.frame_done = 1'b0;

    for (int i = 1; i < NBYTE - 1; i++) send_byte(pat_a[i], 1'b0);
    // Last byte together with frame_done: no swap yet
    bus.in_data    = pat_a[NBYTE-1];
    bus.in_valid   = 1'b1;
    bus.frame_done = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    bus.frame_done = 1'b0;
    chk("wait_ready", 32'(bus.in_ready), 0);
    chk("wait_busy", 32'(bus.load_busy), 1);
    chk("wait_fb_held", 32'(bus.front_bank), 0);
    repeat (10) tick();
    chk("wait10_busy", 32'(bus.load_busy), 1);
    chk("wait10_fb", 32'(bus.front_bank), 0);

    // Swap; read of addr 0 sampled on the swap edge uses the new bank
    bus.rd_addr = '0;
    pulse_fd();
    chk("swap_fb", 32'(bus.front_bank), 1);
    chk("swap_busy", 32'(bus.load_busy), 0);
    chk("swap_ready", 32'(bus.in_ready), 1);
    chk("swap_rd0", 32'(bus.rd_data), 32'h123);
    read_word(AW'(1), d);
    chk("rd1", 32'(d), 32'h456);
    check_image("img_a", exp_a);

    // Reset in the middle of loading bank 0
    send_byte(SYNC_BYTE, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(pat_b[i], 1'b0);
    chk("midload_busy", 32'(bus.load_busy), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.in_ready), 0);
    chk("midrst_fb", 32'(bus.front_bank), 0);
    chk("midrst_busy", 32'(bus.load_busy), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
    chk("midrel_ready", 32'(bus.in_ready), 1);

    // Full reload with random valid gaps into bank 1, with a stray
    // frame_done while loading
    send_byte(8'h3C, 1'b1);
    send_byte(SYNC_BYTE, 1'b1);
    for (int i = 0; i < NBYTE; i++) begin
      if (i == 9) begin
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        chk("fd_in_load_fb", 32'(bus.front_bank), 0);
      end
      send_byte(pat_b[i], 1'b1);
    end
    chk("gap_wait_ready", 32'(bus.in_ready), 0);
    chk("gap_wait_busy", 32'(bus.load_busy), 1);
    pulse_fd();
    chk("gap_swap_fb", 32'(bus.front_bank), 1);
    check_image("img_b", exp_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
